regfile_2w4r: RTL and testbench
===============================

// Module: regfile_2w4r
//
// PURPOSE
//   Architectural GPR file for the dual-issue pipeline: 2 write ports (slot 1 older,
//   slot 2 younger) and 4 asynchronous read ports (rs/rt of both issue slots).
//   Its read data feeds the forwarding muxes as the fallback (non-forwarded) operand.
//   Also holds a per-register load-pending scoreboard used by the load-use stall logic.
//
// PARAMETERS
//   DATA_W  32  register width in bits
//   ADDR_W  5   register address width; NREG = 2**ADDR_W registers
//
// PORTS
//   clk          in   1       rising-edge clock
//   rst          in   1       synchronous, active-high reset
//   wen1         in   1       slot-1 (older) write enable
//   waddr1       in   ADDR_W  slot-1 write address
//   wdata1       in   DATA_W  slot-1 write data
//   wen2         in   1       slot-2 (younger) write enable
//   waddr2       in   ADDR_W  slot-2 write address
//   wdata2       in   DATA_W  slot-2 write data
//   raddr1..4    in   ADDR_W  read addresses (slot1 rs, slot1 rt, slot2 rs, slot2 rt)
//   rdata1..4    out  DATA_W  read data, combinational from raddrN
//   ld_set_en    in   1       a load targeting ld_set_addr issued this cycle
//   ld_set_addr  in   ADDR_W  destination of the issued load
//   ld_flush     in   1       pipeline flush: clear every pending bit
//   pend1..4     out  1       pending bit of raddrN, combinational
//
// BEHAVIOUR
//   - Reset (rst=1 at posedge): all registers <= 0, all pending bits <= 0; rst wins
//     over every write/set/flush in the same cycle. Register 0 always reads 0.
//   - Writes: commit at posedge when wenN=1 and waddrN!=0. Both ports same address:
//     slot-2 data lands (younger wins). Writes to r0 discarded.
//   - Reads: rdataN = reg[raddrN], 0 when raddrN==0; no clock latency. Without the
//     bypass option, a read in the same cycle as a write to that address returns the
//     OLD value; the new value is visible the cycle after.
//   - Scoreboard, per register r, next-state priority (high to low):
//       rst -> 0; ld_flush -> 0; ld_set_en && ld_set_addr==r && r!=0 -> 1;
//       (wen1&&waddr1==r)||(wen2&&waddr2==r) -> 0; else hold.
//     Set beats a same-cycle write-back to the same register (new load is younger).
//     ld_flush beats a same-cycle set (flushed load is discarded). pend for r0 always 0.
//   - pendN = pending[raddrN]; reflects registered state only (no same-cycle view).
//
// CONFIGURATION
//   REGFILE_BYPASS_EN defined: rdataN returns same-cycle write data when a write to
//     raddrN (!=0) is active: wdata2 if wen2 matches, else wdata1 if wen1 matches, else
//     stored value. pendN unaffected.
//   Undefined: pure storage read as described above; forwarding muxes cover the gap.
//
// TESTING
//   1. rst=1 one cycle, then read r1..r31 -> all rdata=0, all pend=0.
//   2. wen1 r5=0x1234_5678; next cycle raddr1=5 -> 0x1234_5678; same cycle -> 0
//      (0x1234_5678 with REGFILE_BYPASS_EN).
//   3. wen1 r7=0xAAAA_AAAA and wen2 r7=0x5555_5555 same cycle -> r7 reads 0x5555_5555.
//   4. wen1 r0=0xFFFF_FFFF; ld_set_en addr 0 -> r0 reads 0, pend for r0 stays 0.
//   5. ld_set r9; next cycle pend=1 on raddr=9; wen2 r9=0x42 -> next cycle pend=0,
//      r9=0x42; ld_set r9 with wen1 r9 same cycle -> pend=1 after.
//   6. ld_set r3,r4 over 2 cycles; ld_flush with ld_set r6 same cycle -> all pend 0;
//      rst asserted mid-write of r8=0x77 -> r8 reads 0.

Source files
------------

// File: rtl/regfile_2w4r_if.sv
// Bus bundle for regfile_2w4r: two write ports, four read ports and the load-pending scoreboard.
`timescale 1ns/1ps
interface regfile_2w4r_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              wen1;
    logic [ADDR_W-1:0] waddr1;
    logic [DATA_W-1:0] wdata1;
    logic              wen2;
    logic [ADDR_W-1:0] waddr2;
    logic [DATA_W-1:0] wdata2;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic [ADDR_W-1:0] raddr3;
    logic [ADDR_W-1:0] raddr4;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] rdata3;
    logic [DATA_W-1:0] rdata4;
    logic              ld_set_en;
    logic [ADDR_W-1:0] ld_set_addr;
    logic              ld_flush;
    logic              pend1;
    logic              pend2;
    logic              pend3;
    logic              pend4;

    // No handshake: every request is accepted in the cycle it is presented.
    modport master (
        output wen1, waddr1, wdata1, wen2, waddr2, wdata2,
        output raddr1, raddr2, raddr3, raddr4,
        output ld_set_en, ld_set_addr, ld_flush,
        input  rdata1, rdata2, rdata3, rdata4,
        input  pend1, pend2, pend3, pend4
    );

    modport slave (
        input  wen1, waddr1, wdata1, wen2, waddr2, wdata2,
        input  raddr1, raddr2, raddr3, raddr4,
        input  ld_set_en, ld_set_addr, ld_flush,
        output rdata1, rdata2, rdata3, rdata4,
        output pend1, pend2, pend3, pend4
    );
endinterface

// File: rtl/regfile_2w4r.sv
// Dual-issue GPR file: 2 write ports (slot 2 younger), 4 async read ports, load-pending scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
`timescale 1ns/1ps
module regfile_2w4r #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic          clk,
    input  logic          rst,
    regfile_2w4r_if.slave bus
);
    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   pending;
    logic [NREG-1:0]   pending_nxt;
    logic [ADDR_W-1:0] raddr [4];
    logic [DATA_W-1:0] rdata [4];
    logic              pend  [4];

    assign raddr[0] = bus.raddr1;
    assign raddr[1] = bus.raddr2;
    assign raddr[2] = bus.raddr3;
    assign raddr[3] = bus.raddr4;

    assign bus.rdata1 = rdata[0];
    assign bus.rdata2 = rdata[1];
    assign bus.rdata3 = rdata[2];
    assign bus.rdata4 = rdata[3];
    assign bus.pend1  = pend[0];
    assign bus.pend2  = pend[1];
    assign bus.pend3  = pend[2];
    assign bus.pend4  = pend[3];

    // Flush beats a new load, and a new load beats an older load's write-back.
    always_comb begin
        pending_nxt = pending;
        for (int r = 1; r < NREG; r++) begin
            if (bus.ld_flush) begin
                pending_nxt[r] = 1'b0;
            end else if (bus.ld_set_en && bus.ld_set_addr == ADDR_W'(r)) begin
                pending_nxt[r] = 1'b1;
            end else if ((bus.wen1 && bus.waddr1 == ADDR_W'(r)) ||
                         (bus.wen2 && bus.waddr2 == ADDR_W'(r))) begin
                pending_nxt[r] = 1'b0;
            end
        end
        pending_nxt[0] = 1'b0;
    end

    // Slot 2 is assigned last so it lands when both ports hit the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
            pending <= '0;
        end else begin
            if (bus.wen1 && bus.waddr1 != '0) begin
                regs[bus.waddr1] <= bus.wdata1;
            end
            if (bus.wen2 && bus.waddr2 != '0) begin
                regs[bus.waddr2] <= bus.wdata2;
            end
            pending <= pending_nxt;
        end
    end

    always_comb begin
        for (int p = 0; p < 4; p++) begin
            rdata[p] = (raddr[p] == '0) ? '0 : regs[raddr[p]];
`ifdef REGFILE_BYPASS_EN
            if (raddr[p] != '0) begin
                if (bus.wen2 && bus.waddr2 == raddr[p]) begin
                    rdata[p] = bus.wdata2;
                end else if (bus.wen1 && bus.waddr1 == raddr[p]) begin
                    rdata[p] = bus.wdata1;
                end
            end
`endif
            pend[p] = pending[raddr[p]];
        end
    end
endmodule

// File: tb/tb_regfile_2w4r.sv
// Directed bench for regfile_2w4r: writes, read ordering, r0 rules and scoreboard priority.
`timescale 1ns/1ps
module tb_regfile_2w4r;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    regfile_2w4r_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_2w4r #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.wen1 = 1'b0; bus.waddr1 = '0; bus.wdata1 = '0;
        bus.wen2 = 1'b0; bus.waddr2 = '0; bus.wdata2 = '0;
        bus.ld_set_en = 1'b0; bus.ld_set_addr = '0; bus.ld_flush = 1'b0;
    endtask

    task automatic set_raddr(input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2,
                             input logic [ADDR_W-1:0] a3, input logic [ADDR_W-1:0] a4);
        bus.raddr1 = a1; bus.raddr2 = a2; bus.raddr3 = a3; bus.raddr4 = a4;
        #1;
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        set_raddr(0, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // 1: reset state on every register and every read port
        for (int r = 1; r < 32; r++) begin
            set_raddr(ADDR_W'(r), ADDR_W'(r), ADDR_W'(r), ADDR_W'(r));
            check($sformatf("rst_rdata1_r%0d", r), bus.rdata1, 32'h0);
            check($sformatf("rst_pend1_r%0d", r), 32'(bus.pend1), 32'h0);
        end
        check("rst_rdata4_r31", bus.rdata4, 32'h0);
        check("rst_pend3_r31", 32'(bus.pend3), 32'h0);

        // 2: write r5, same-cycle and next-cycle reads
        bus.wen1 = 1'b1; bus.waddr1 = 5; bus.wdata1 = 32'h1234_5678;
        set_raddr(5, 0, 0, 5);
        check("w5_same_cycle", bus.rdata1, BYPASS ? 32'h1234_5678 : 32'h0);
        check("w5_same_cycle_p4", bus.rdata4, BYPASS ? 32'h1234_5678 : 32'h0);
        tick();
        idle();
        #1;
        check("w5_next_cycle", bus.rdata1, 32'h1234_5678);
        check("w5_next_cycle_p4", bus.rdata4, 32'h1234_5678);

        // 3: both ports write r7, younger wins
        bus.wen1 = 1'b1; bus.waddr1 = 7; bus.wdata1 = 32'hAAAA_AAAA;
        bus.wen2 = 1'b1; bus.waddr2 = 7; bus.wdata2 = 32'h5555_5555;
        set_raddr(0, 7, 0, 0);
        check("w7_same_cycle", bus.rdata2, BYPASS ? 32'h5555_5555 : 32'h0);
        tick();
        idle();
        #1;
        check("w7_younger_wins", bus.rdata2, 32'h5555_5555);

        // distinct addresses on both ports, and a disabled write
        bus.wen1 = 1'b1; bus.waddr1 = 11; bus.wdata1 = 32'hBEEF_0011;
        bus.wen2 = 1'b1; bus.waddr2 = 10; bus.wdata2 = 32'hDEAD_0010;
        tick();
        idle();
        bus.waddr1 = 12; bus.wdata1 = 32'hCAFE_0012;
        tick();
        idle();
        set_raddr(10, 11, 12, 5);
        check("dual_w_r10", bus.rdata1, 32'hDEAD_0010);
        check("dual_w_r11", bus.rdata2, 32'hBEEF_0011);
        check("no_wen_r12", bus.rdata3, 32'h0);
        check("r5_kept", bus.rdata4, 32'h1234_5678);

        // 4: r0 ignores writes and load sets
        bus.wen1 = 1'b1; bus.waddr1 = 0; bus.wdata1 = 32'hFFFF_FFFF;
        bus.ld_set_en = 1'b1; bus.ld_set_addr = 0;
        set_raddr(0, 0, 0, 0);
        check("r0_same_cycle", bus.rdata3, 32'h0);
        tick();
        idle();
        #1;
        check("r0_rdata", bus.rdata3, 32'h0);
        check("r0_pend", 32'(bus.pend3), 32'h0);

        // 5: scoreboard set / clear by write-back / set beats write-back
        bus.ld_set_en = 1'b1; bus.ld_set_addr = 9;
        set_raddr(9, 0, 0, 0);
        check("p9_not_same_cycle", 32'(bus.pend1), 32'h0);
        tick();
        idle();
        #1;
        check("p9_set", 32'(bus.pend1), 32'h1);
        bus.wen2 = 1'b1; bus.waddr2 = 9; bus.wdata2 = 32'h42;
        #1;
        check("p9_held_during_wb", 32'(bus.pend1), 32'h1);
        tick();
        idle();
        #1;
        check("p9_cleared_by_wb", 32'(bus.pend1), 32'h0);
        check("r9_wb_data", bus.rdata1, 32'h42);
        bus.ld_set_en = 1'b1; bus.ld_set_addr = 9;
        bus.wen1 = 1'b1; bus.waddr1 = 9; bus.wdata1 = 32'h99;
        tick();
        idle();
        #1;
        check("p9_set_beats_wb", 32'(bus.pend1), 32'h1);
        check("r9_wb2_data", bus.rdata1, 32'h99);

        // set on one register does not disturb another written the same cycle
        bus.ld_set_en = 1'b1; bus.ld_set_addr = 12;
        bus.wen1 = 1'b1; bus.waddr1 = 13; bus.wdata1 = 32'h13;
        tick();
        idle();
        set_raddr(12, 13, 9, 0);
        check("p12_set", 32'(bus.pend1), 32'h1);
        check("p13_clear", 32'(bus.pend2), 32'h0);
        check("p9_still_set", 32'(bus.pend3), 32'h1);

        // 6: flush beats a same-cycle set
        bus.ld_set_en = 1'b1; bus.ld_set_addr = 3;
        tick();
        bus.ld_set_addr = 4;
        tick();
        idle();
        set_raddr(3, 4, 6, 9);
        check("p3_set", 32'(bus.pend1), 32'h1);
        check("p4_set", 32'(bus.pend2), 32'h1);
        bus.ld_flush = 1'b1;
        bus.ld_set_en = 1'b1; bus.ld_set_addr = 6;
        tick();
        idle();
        #1;
        check("flush_p3", 32'(bus.pend1), 32'h0);
        check("flush_p4", 32'(bus.pend2), 32'h0);
        check("flush_p6", 32'(bus.pend3), 32'h0);
        check("flush_p9", 32'(bus.pend4), 32'h0);

        // reset wins over a same-cycle write and set
        bus.ld_set_en = 1'b1; bus.ld_set_addr = 14;
        tick();
        idle();
        bus.wen1 = 1'b1; bus.waddr1 = 8; bus.wdata1 = 32'h77;
        bus.ld_set_en = 1'b1; bus.ld_set_addr = 15;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        set_raddr(8, 5, 14, 15);
        check("rst_mid_write_r8", bus.rdata1, 32'h0);
        check("rst_clears_r5", bus.rdata2, 32'h0);
        check("rst_clears_p14", 32'(bus.pend3), 32'h0);
        check("rst_beats_set_p15", 32'(bus.pend4), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
